// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures imem words into the IF/ID register, and handles redirect, stall and halt.
// Optional issued-instruction counter is built only when FETCH_PERF_COUNT_EN is defined.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // 33-bit bounds so a window touching the top of the address space cannot overflow.
    localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * IMEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;

    logic [31:0] target_aligned;
    logic        in_window;

    assign target_aligned = redirect_target & ~32'h3;
    assign in_window      = ({1'b0, pc_q} >= WIN_LO) && ({1'b0, pc_q} < WIN_HI);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (redirect_valid) pc_d = target_aligned;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    valid_d = 1'b0;
                end else if (!valid_q || id_ready) begin
                    if (imem_instr == 32'h0 || !in_window) begin
                        valid_d = 1'b0;
                        state_d = ST_HALT;
                    end else begin
                        instr_d = imem_instr;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign imem_pc  = pc_q;
    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc    = ipc_q;
    assign halted   = (state_q == ST_HALT);

`ifdef FETCH_PERF_COUNT_EN
    // Counts accepted handshakes, including one that coincides with a squashing redirect.
    logic        handshake;
    logic [31:0] count_q, count_d;

    assign handshake = valid_q && id_ready;
    assign count_d   = count_q + 32'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 32'h0;
        end else if (handshake) begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed plan steps followed by random traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 32;
`ifdef FETCH_PERF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [IMEM_WORDS];
    logic [31:0] dut_idx;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    bit          m_valid, m_halted, m_booting;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
        .clock(clock), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    function automatic bit in_win(logic [31:0] pc);
        longint off;
        off = longint'(pc) - longint'(RESET_PC);
        return (off >= 0) && (off < 4 * IMEM_WORDS);
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] pc);
        longint off;
        off = longint'(pc) - longint'(RESET_PC);
        if (in_win(pc)) return mem[int'(off / 4)];
        return 32'hDEAD_BEEF;
    endfunction

    assign dut_idx    = (imem_pc - RESET_PC) >> 2;
    assign imem_instr = in_win(imem_pc) ? mem[dut_idx[4:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge of the fetch rules, applied to the inputs as they stand before the edge.
    task automatic model_step();
        logic [31:0] w;
        if (reset) begin
            m_pc = RESET_PC; m_valid = 0; m_instr = 0; m_ipc = 0;
            m_halted = 0; m_booting = 1; m_cnt = 0;
            return;
        end
        if (CNT_EN && m_valid && id_ready) m_cnt = m_cnt + 1;
        if (m_booting) begin
            m_booting = 0;
            if (redirect_valid) m_pc = redirect_target & ~32'h3;
        end else if (m_halted) begin
            if (redirect_valid) begin
                m_pc = redirect_target & ~32'h3;
                m_halted = 0;
            end
        end else if (redirect_valid) begin
            m_pc = redirect_target & ~32'h3;
            m_valid = 0;
        end else if (!m_valid || id_ready) begin
            w = word_at(m_pc);
            if (w == 0 || !in_win(m_pc)) begin
                m_valid = 0;
                m_halted = 1;
            end else begin
                m_instr = w; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        chk("imem_pc", imem_pc, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ipc);
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("fetch_count", fetch_count, m_cnt);
        $display("cyc rst=%0b rdv=%0b tgt=%h rdy=%0b | pc=%h v=%0b ipc=%h ins=%h h=%0b cnt=%0d",
                 reset, redirect_valid, redirect_target, id_ready,
                 imem_pc, if_valid, if_pc, if_instr, halted, fetch_count);
    endtask

    task automatic do_reset();
        reset = 1; redirect_valid = 0; id_ready = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1; redirect_valid = 0; redirect_target = 0; id_ready = 1;
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'h0;
        mem[0] = 32'h001080B3; mem[1] = 32'h001080B3; mem[2] = 32'h001080B3; mem[3] = 32'h0;

        // Basic fetch then halt on empty word
        do_reset();
        chk("reset_pc", imem_pc, RESET_PC);
        chk("reset_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("boot_no_issue", {31'b0, if_valid}, 32'd0);
        tick(); chk("plan_if_pc0", if_pc, 32'h0);
        tick(); chk("plan_if_pc4", if_pc, 32'h4);
        tick(); chk("plan_if_pc8", if_pc, 32'h8);
        tick();
        chk("plan_halt", {31'b0, halted}, 32'd1);
        chk("plan_halt_pc", imem_pc, 32'hC);

        // Stall, redirect, out-of-window, reset mid-stall
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'h1000_0013 + 32'(i);
        do_reset();
        tick(); tick(); tick();
        chk("stall_pre_ipc", if_pc, 32'h4);
        id_ready = 0;
        tick(); tick(); tick();
        chk("stall_pc", imem_pc, 32'h8);
        chk("stall_ipc", if_pc, 32'h4);
        id_ready = 1;
        tick();
        chk("stall_release", if_pc, 32'h8);
        id_ready = 0; tick();
        redirect_valid = 1; redirect_target = 32'h13;
        tick();
        chk("redir_squash", {31'b0, if_valid}, 32'd0);
        chk("redir_pc", imem_pc, 32'h10);
        redirect_valid = 0; id_ready = 1;
        tick();
        chk("redir_ipc", if_pc, 32'h10);
        redirect_valid = 1; redirect_target = 32'h80;
        tick();
        redirect_valid = 0;
        tick();
        chk("oow_halt", {31'b0, halted}, 32'd1);
        redirect_valid = 1; redirect_target = 32'h4;
        tick();
        chk("oow_resume", {31'b0, halted}, 32'd0);
        redirect_valid = 0;
        tick();
        chk("oow_ipc", if_pc, 32'h4);
        redirect_valid = 1; redirect_target = 32'h1C;
        tick();
        redirect_valid = 0; id_ready = 0;
        tick(); tick();
        chk("midstall_pc", imem_pc, 32'h20);
        reset = 1;
        tick();
        chk("midstall_reset_pc", imem_pc, RESET_PC);
        chk("midstall_reset_cnt", fetch_count, 32'h0);
        reset = 0; id_ready = 1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                for (int j = 0; j < IMEM_WORDS; j++)
                    mem[j] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
            end
            reset          = ($urandom_range(0, 149) == 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) redirect_target = $urandom;
            else redirect_target = RESET_PC + 32'($urandom_range(0, 35) * 4) + 32'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
